// File: rtl/fifo_read_drainer_if.sv
// Read-side bundle for the FIFO drainer.
// It groups the FIFO pop port (rdata/rempty/rinc) and the downstream
// valid/ready stream (m_data/m_valid/m_ready/m_last).
// The drainer uses the master modport. The FIFO and consumer side uses slave.
interface fifo_read_drainer_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    input  rdata,
    input  rempty,
    input  m_ready,
    output rinc,
    output m_data,
    output m_valid,
    output m_last
  );

  modport slave (
    output rdata,
    output rempty,
    output m_ready,
    input  rinc,
    input  m_data,
    input  m_valid,
    input  m_last
  );
endinterface

// File: rtl/fifo_read_drainer.sv
// Read-side engine for the async FIFO, living entirely in the rclk domain.
// It pops show-ahead words while the FIFO is non-empty and the 2-entry
// output buffer has room, and presents them on a valid/ready stream.
// Every BURST-th popped word is tagged last.
// Enable is honoured only at burst boundaries, so a started burst always
// runs to completion.
module fifo_read_drainer #(
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  parameter int CNTW  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 enable,
  fifo_read_drainer_if.master  bus,
  output logic [CNTW-1:0]      rd_count,
  output logic                 busy
);

  // The beat index needs at least one bit even when BURST is 1.
  localparam int             BW        = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0]  BEAT_LAST = BW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // One buffered word together with its end-of-burst tag.
  typedef struct packed {
    logic             last;
    logic [DSIZE-1:0] data;
  } entry_t;

  state_t          state_q, state_d;
  logic [1:0]      occ_q, occ_d;
  entry_t          head_q, head_d;
  entry_t          tail_q, tail_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            pop;
  logic            xfer;
  logic            beat_wrap;
  entry_t          in_word;

  // Pop and transfer qualifiers, built from registered occupancy only.
  // There is no same-cycle pass-through credit.
  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pop          = 1'b0;
    xfer         = 1'b0;
    beat_wrap    = 1'b0;
    in_word      = '0;
    pop          = (state_q != IDLE) && !bus.rempty && (occ_q != 2'd2);
    xfer         = (occ_q != 2'd0) && bus.m_ready;
    beat_wrap    = (beat_q == BEAT_LAST);
    in_word.last = beat_wrap;
    in_word.data = bus.rdata;
  end

  // Beat index: advance on each pop, wrapping after the last word of a burst.
  always_comb begin
    beat_d = beat_q;
    if (pop) begin
      beat_d = beat_wrap ? '0 : beat_q + 1'b1;
    end
  end

  // Burst FSM.
  // Enable is only looked at when the beat index, including this cycle's pop, sits at 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && !bus.rempty) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = (beat_d == '0) ? IDLE : FINISH;
        end
      end
      FINISH: begin
        if (beat_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry output buffer (head presented, tail behind it), order preserved.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({pop, xfer})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = in_word;
        end else begin
          tail_d = in_word;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      // Pop and transfer together can only happen at occupancy 1.
      // The new word replaces the departing head.
      2'b11: begin
        head_d = in_word;
      end
      default: ;
    endcase
  end

  // Popped-word counter, wrapping naturally modulo 2^CNTW.
  always_comb begin
    cnt_d = cnt_q + CNTW'(pop);
  end

  // State registers with asynchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the buffer entries are reset as well as the occupancy, so m_data and m_last read 0 out of reset.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rinc    = pop;
  assign bus.m_data  = head_q.data;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_last  = (occ_q != 2'd0) && head_q.last;
  assign rd_count    = cnt_q;
  assign busy        = (state_q != IDLE) || (occ_q != 2'd0);

  // Pops must never hit an empty FIFO or a full buffer.
  a_pop_safe: assert property (@(posedge rclk) disable iff (rrst)
    bus.rinc |-> (!bus.rempty && (occ_q != 2'd2)));

endmodule

// File: doc/fifo_read_drainer.md
Name: fifo_read_drainer

Overview:
- Read-side engine for the async FIFO.
- Sits in the rclk domain and pops words whenever the FIFO is non-empty and there is room downstream.
- Presents the words on a valid/ready stream through a 2-entry output buffer, tagging every BURST-th popped word as last.
- Gates on enable only at burst boundaries: a burst that has started always completes.

Parameters:
- DSIZE, 8, data word width; matches FIFO DSIZE.
- BURST, 4, words per burst; m_last marks the final word; must be ≥1.
- CNTW, 16, width of the popped-word counter rd_count.

Ports:
- rclk  input  1  read-domain clock; all logic on posedge.
- rrst  input  1  asynchronous, active-high reset.
- rdata  input  DSIZE  FIFO read data; valid combinationally whenever rempty=0 (show-ahead).
- rempty  input  1  FIFO empty flag, already in the rclk domain.
- rinc  output  1  FIFO pop strobe; one word is consumed per rclk edge while high.
- enable  input  1  permission to start new bursts.
- m_data  output  DSIZE  output word (head of buffer).
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accepts; transfer occurs when m_valid && m_ready at posedge.
- m_last  output  1  head word is the last of its burst.
- rd_count  output  CNTW  total words popped since reset; wraps modulo 2^CNTW.
- busy  output  1  state != IDLE, or buffer non-empty.

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE, buffer occupancy to 0, beat index to 0 and rd_count to 0.
  - m_valid=0, m_last=0, m_data=0, busy=0.
  - rinc=0 immediately, since rinc is combinational from reset-cleared state.
- Reset mid-operation: buffered words are discarded, not emitted. The FIFO pointers are not touched by this block.
- States:
  - IDLE:
    - rinc=0.
    - Go to RUN when enable=1 && rempty=0; no pop in that cycle.
  - RUN:
    - pop = !rempty && occupancy<2; rinc=pop.
    - On each pop, beat index increments; at BURST-1 it wraps to 0 and the captured word carries last=1.
    - When enable=0 and the beat index is 0 (taking any same-cycle pop into account), go to IDLE.
    - When enable=0 and the beat index is non-zero, go to FINISH.
  - FINISH:
    - Same pop rule as RUN.
    - When the beat index returns to 0, go to IDLE.
    - Re-asserting enable in FINISH does not cancel it; the next burst starts from IDLE.
- Output buffer:
  - 2-entry FIFO of {word, last}, order preserved.
  - A pop and a downstream transfer may occur in the same cycle; occupancy is then unchanged.
  - The occupancy<2 test uses registered occupancy; there is no same-cycle pass-through credit.
  - With m_ready held high the occupancy never exceeds 1, so one word per cycle is sustained.
- Latency:
  - Pop at edge N makes the word visible on m_data/m_valid after edge N.
  - enable rising with a non-empty FIFO gives m_valid high 2 cycles later.
- Stall rules: m_data and m_last stay stable while m_valid && !m_ready.
- FIFO empty mid-burst:
  - The block stays in RUN/FINISH with rinc=0.
  - m_valid drops once the buffer drains.
  - The burst resumes when rempty falls; m_last still lands on the BURST-th word.
- rd_count: increments by 1 on every edge with rinc=1 and wraps to 0 after 2^CNTW-1.
- rinc never asserts while rempty=1, or while occupancy is 2.

Test Plan:
1. Directed burst.
   - Stimulus: DSIZE=8, BURST=4. FIFO holds 11,22,33,44; enable=1; m_ready=1.
   - Required response: m_data 11,22,33,44 on 4 consecutive cycles, m_last only with 44, rd_count=4, then IDLE with busy=0.
2. Backpressure.
   - Stimulus: 6 words queued, m_ready=0.
   - Required response: exactly 2 pops, then rinc=0 and rd_count=2, m_data holding the first word. After m_ready=1, all 6 words emerge in order, and m_last is asserted only on the 4th word.
3. Enable drop mid-burst.
   - Stimulus: deassert enable after 2 pops, with 10 words queued.
   - Required response: state goes to FINISH, exactly 2 more pops, m_last on the 4th word, then IDLE. rd_count=4 and 6 words remain in the FIFO.
4. Empty mid-burst.
   - Stimulus: FIFO holds 2 words, then 2 more are written 20 cycles later.
   - Required response: after 2 words m_valid=0 and rinc=0 with state RUN. The write resumes output and m_last lands on the 4th word.
5. Reset mid-operation.
   - Stimulus: assert rrst between edges with 2 words buffered.
   - Required response: m_valid=0, rinc=0, rd_count=0 and busy=0 immediately. After release, the first output is a first-of-burst word (beat index 0).
6. Counter wrap.
   - Stimulus: CNTW=4, 20 words popped.
   - Required response: rd_count=4, no data loss, and m_last on words 4, 8, 12, 16 and 20.
